wb_stage_multilane: RTL and testbench

- Parametrised successor writeback stage for the multi-issue core: retires a bundle of LANES instructions per cycle from MEM to the register file.
- Unlike the single-lane stage, load data arrives through a per-lane valid handshake, so the stage can wait for late responses.
- Flushed loads have their responses discarded.
- Resolves same-register write collisions inside a bundle; exports per-lane forwarding and registered debug ports.

---
 rtl/wb_stage_multilane.sv | 236 +++++++++++++++++++++++
 tb/tb_wb_stage_multilane.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_multilane.sv
// Multi-lane writeback stage: holds one MEM bundle, waits for per-lane load
// responses, extracts load data and retires all lanes to the register file.
//
// state | meaning
// EMPTY | no bundle held
// WAIT  | bundle held, at least one load response outstanding
// DONE  | bundle complete, retires when commit_ok
module wb_stage_multilane #(
    parameter int LANES  = 2,
    parameter int GPR_W  = 5,
    parameter int LSEL_W = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      commit_ok,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*GPR_W-1:0]    in_wnum,
    input  logic [LANES*32-1:0]       in_res,
    input  logic [LANES*LSEL_W-1:0]   in_load,
    input  logic [LANES*2-1:0]        in_align,
    input  logic [LANES*32-1:0]       in_rt,
    input  logic [LANES*32-1:0]       in_pc,
    input  logic [LANES-1:0]          rdata_valid,
    input  logic [LANES*32-1:0]       rdata,
    output logic [LANES-1:0]          wb_wen,
    output logic [LANES*GPR_W-1:0]    wb_wnum,
    output logic [LANES*32-1:0]       wb_wdata,
    output logic [LANES*GPR_W-1:0]   fwd_num,
    output logic [LANES-1:0]          fwd_ready,
    output logic [LANES*32-1:0]       fwd_data,
    output logic                      busy_wait,
    output logic [LANES*32-1:0]       debug_pc,
    output logic [LANES*4-1:0]        debug_wen,
    output logic [LANES*GPR_W-1:0]    debug_wnum,
    output logic [LANES*32-1:0]       debug_wdata
);

    localparam logic [LSEL_W-1:0] LD_NONE = LSEL_W'(0);
    localparam logic [LSEL_W-1:0] LD_LB   = LSEL_W'(1);
    localparam logic [LSEL_W-1:0] LD_LBU  = LSEL_W'(2);
    localparam logic [LSEL_W-1:0] LD_LH   = LSEL_W'(3);
    localparam logic [LSEL_W-1:0] LD_LHU  = LSEL_W'(4);
    localparam logic [LSEL_W-1:0] LD_LW   = LSEL_W'(5);
    localparam logic [LSEL_W-1:0] LD_LWL  = LSEL_W'(6);
    localparam logic [LSEL_W-1:0] LD_LWR  = LSEL_W'(7);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [LANES-1:0][GPR_W-1:0]  wnum_q, wnum_d;
    logic [LANES-1:0][31:0]       res_q, res_d;
    logic [LANES-1:0][LSEL_W-1:0] load_q, load_d;
    logic [LANES-1:0][1:0]        align_q, align_d;
    logic [LANES-1:0][31:0]       rt_q, rt_d;
    logic [LANES-1:0][31:0]       pc_q, pc_d;
    logic [LANES-1:0][31:0]       buf_q, buf_d;
    logic [LANES-1:0]             have_q, have_d;
    logic [LANES-1:0]             drop_q, drop_d;

    logic [LANES-1:0][31:0]       final_data;
    logic [LANES-1:0]             awaiting;
    logic [LANES-1:0]             wen_c;
    logic                         has_data;
    logic                         retire;
    logic                         accept;

    function automatic logic [31:0] load_extract(
        input logic [LSEL_W-1:0] code,
        input logic [1:0]        a,
        input logic [31:0]       rt,
        input logic [31:0]       mem
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [4:0]  sh;
        logic [4:0]  sh_l;
        logic [31:0] r;
        sh   = {a, 3'b000};
        sh_l = {2'd3 - a, 3'b000};
        b    = mem[sh +: 8];
        h    = a[1] ? mem[31:16] : mem[15:0];
        case (code)
            LD_LB:   r = {{24{b[7]}}, b};
            LD_LBU:  r = {24'd0, b};
            LD_LH:   r = {{16{h[15]}}, h};
            LD_LHU:  r = {16'd0, h};
            LD_LW:   r = mem;
            // mem bytes [a:0] go to the top, rt keeps the low 3-a bytes
            LD_LWL:  r = (mem << sh_l) | (rt & (32'h00FF_FFFF >> sh));
            // mem bytes [3:a] go to the bottom, rt keeps the top a bytes
            LD_LWR:  r = (mem >> sh) | (rt & ~(32'hFFFF_FFFF >> sh));
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    assign has_data  = (state_q != ST_EMPTY);
    assign in_ready  = (state_q == ST_EMPTY) || ((state_q == ST_DONE) && commit_ok);
    assign accept    = in_valid && in_ready && !flush;
    assign retire    = (state_q == ST_DONE) && commit_ok && !flush;
    assign busy_wait = (state_q == ST_WAIT);

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            awaiting[i]   = (state_q == ST_WAIT) && (load_q[i] != LD_NONE) && !have_q[i];
            final_data[i] = (load_q[i] != LD_NONE) ?
                            load_extract(load_q[i], align_q[i], rt_q[i], buf_q[i]) : res_q[i];
        end
    end

    // Only the youngest lane writing a given register retires its write.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            wen_c[i] = retire && (wnum_q[i] != '0);
            for (int j = i + 1; j < LANES; j++) begin
                if (wnum_q[j] == wnum_q[i]) wen_c[i] = 1'b0;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            wb_wnum[i*GPR_W +: GPR_W]  = wnum_q[i];
            wb_wdata[i*32 +: 32]        = final_data[i];
            fwd_num[i*GPR_W +: GPR_W]  = has_data ? wnum_q[i] : '0;
            fwd_ready[i]                = has_data && have_q[i];
            fwd_data[i*32 +: 32]        = final_data[i];
        end
        wb_wen = wen_c;
    end

    always_comb begin
        state_d = state_q;
        wnum_d  = wnum_q;
        res_d   = res_q;
        load_d  = load_q;
        align_d = align_q;
        rt_d    = rt_q;
        pc_d    = pc_q;
        buf_d   = buf_q;
        have_d  = have_q;
        drop_d  = drop_q;

        for (int i = 0; i < LANES; i++) begin
            if (rdata_valid[i] && drop_q[i]) drop_d[i] = 1'b0;

            if (flush) begin
                have_d[i] = 1'b0;
                // A response arriving with the flush belongs to the dead load.
                if (awaiting[i] && !(rdata_valid[i] && !drop_q[i])) drop_d[i] = 1'b1;
            end else if (accept) begin
                wnum_d[i]  = in_wnum[i*GPR_W +: GPR_W];
                res_d[i]   = in_res[i*32 +: 32];
                load_d[i]  = in_load[i*LSEL_W +: LSEL_W];
                align_d[i] = in_align[i*2 +: 2];
                rt_d[i]    = in_rt[i*32 +: 32];
                pc_d[i]    = in_pc[i*32 +: 32];
                if (in_load[i*LSEL_W +: LSEL_W] == LD_NONE) begin
                    have_d[i] = 1'b1;
                end else if (rdata_valid[i] && !drop_q[i]) begin
                    have_d[i] = 1'b1;
                    buf_d[i]  = rdata[i*32 +: 32];
                end else begin
                    have_d[i] = 1'b0;
                end
            end else if (awaiting[i] && rdata_valid[i] && !drop_q[i]) begin
                have_d[i] = 1'b1;
                buf_d[i]  = rdata[i*32 +: 32];
            end else if (retire) begin
                have_d[i] = 1'b0;
            end
        end

        if (flush) begin
            state_d = ST_EMPTY;
        end else if (accept) begin
            state_d = (&have_d) ? ST_DONE : ST_WAIT;
        end else begin
            case (state_q)
                ST_WAIT: if (&have_d) state_d = ST_DONE;
                ST_DONE: if (commit_ok) state_d = ST_EMPTY;
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
            wnum_q  <= '0;
            res_q   <= '0;
            load_q  <= '0;
            align_q <= '0;
            rt_q    <= '0;
            pc_q    <= '0;
            buf_q   <= '0;
            have_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            wnum_q  <= wnum_d;
            res_q   <= res_d;
            load_q  <= load_d;
            align_q <= align_d;
            rt_q    <= rt_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
            have_q  <= have_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            debug_pc    <= '0;
            debug_wen   <= '0;
            debug_wnum  <= '0;
            debug_wdata <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                debug_wen[i*4 +: 4]          <= {4{wen_c[i]}};
                debug_pc[i*32 +: 32]         <= retire ? pc_q[i] : 32'd0;
                debug_wnum[i*GPR_W +: GPR_W] <= retire ? wnum_q[i] : '0;
                debug_wdata[i*32 +: 32]      <= retire ? final_data[i] : 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_wb_stage_multilane.sv
// Directed bench for wb_stage_multilane: inputs driven on the falling edge,
// outputs checked 1 time unit later against hand-computed values.
module tb_wb_stage_multilane;

    localparam int LANES  = 2;
    localparam int GPR_W  = 5;
    localparam int LSEL_W = 3;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    flush;
    logic                    commit_ok;
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*GPR_W-1:0]  in_wnum;
    logic [LANES*32-1:0]     in_res;
    logic [LANES*LSEL_W-1:0] in_load;
    logic [LANES*2-1:0]      in_align;
    logic [LANES*32-1:0]     in_rt;
    logic [LANES*32-1:0]     in_pc;
    logic [LANES-1:0]        rdata_valid;
    logic [LANES*32-1:0]     rdata;
    logic [LANES-1:0]        wb_wen;
    logic [LANES*GPR_W-1:0]  wb_wnum;
    logic [LANES*32-1:0]     wb_wdata;
    logic [LANES*GPR_W-1:0]  fwd_num;
    logic [LANES-1:0]        fwd_ready;
    logic [LANES*32-1:0]     fwd_data;
    logic                    busy_wait;
    logic [LANES*32-1:0]     debug_pc;
    logic [LANES*4-1:0]      debug_wen;
    logic [LANES*GPR_W-1:0]  debug_wnum;
    logic [LANES*32-1:0]     debug_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    wb_stage_multilane #(.LANES(LANES), .GPR_W(GPR_W), .LSEL_W(LSEL_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .commit_ok(commit_ok),
        .in_valid(in_valid), .in_ready(in_ready), .in_wnum(in_wnum),
        .in_res(in_res), .in_load(in_load), .in_align(in_align),
        .in_rt(in_rt), .in_pc(in_pc), .rdata_valid(rdata_valid),
        .rdata(rdata), .wb_wen(wb_wen), .wb_wnum(wb_wnum),
        .wb_wdata(wb_wdata), .fwd_num(fwd_num), .fwd_ready(fwd_ready),
        .fwd_data(fwd_data), .busy_wait(busy_wait), .debug_pc(debug_pc),
        .debug_wen(debug_wen), .debug_wnum(debug_wnum),
        .debug_wdata(debug_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_lane(input int i, input logic [4:0] wn, input logic [31:0] res,
                            input logic [2:0] ld, input logic [1:0] al,
                            input logic [31:0] rt, input logic [31:0] pc);
        in_wnum[i*GPR_W +: GPR_W]   = wn;
        in_res[i*32 +: 32]          = res;
        in_load[i*LSEL_W +: LSEL_W] = ld;
        in_align[i*2 +: 2]          = al;
        in_rt[i*32 +: 32]           = rt;
        in_pc[i*32 +: 32]           = pc;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; commit_ok = 1'b0; in_valid = 1'b0;
        in_wnum = '0; in_res = '0; in_load = '0; in_align = '0;
        in_rt = '0; in_pc = '0; rdata_valid = '0; rdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy_wait, 0);
        check("rst_wen", wb_wen, 0);
        check("rst_dbg_wen", debug_wen, 0);
        check("rst_fwd_ready", fwd_ready, 0);

        // 1: two ALU lanes
        @(negedge clk);
        set_lane(0, 5'd3, 32'h11, 3'd0, 2'd0, 32'h0, 32'h100);
        set_lane(1, 5'd4, 32'h22, 3'd0, 2'd0, 32'h0, 32'h104);
        in_valid = 1'b1; commit_ok = 1'b1;
        #1 check("t1_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("t1_wen", wb_wen, 2'b11);
        check("t1_wdata", wb_wdata, {32'h22, 32'h11});
        check("t1_wnum", wb_wnum, {5'd4, 5'd3});
        check("t1_dbg_before", debug_wen, 0);
        @(negedge clk);
        #1;
        check("t1_dbg_wen", debug_wen, 8'hFF);
        check("t1_dbg_wdata", debug_wdata, {32'h22, 32'h11});
        check("t1_dbg_pc", debug_pc, {32'h104, 32'h100});
        check("t1_dbg_wnum", debug_wnum, {5'd4, 5'd3});
        check("t1_wen_idle", wb_wen, 0);

        // 2: LB with response 3 cycles late
        set_lane(0, 5'd7, 32'h0, 3'd1, 2'd2, 32'h0, 32'h200);
        set_lane(1, 5'd0, 32'h0, 3'd0, 2'd0, 32'h0, 32'h204);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1 check("t2_busy1", busy_wait, 1);
        check("t2_fwd_rdy", fwd_ready, 2'b10);
        check("t2_wen_wait", wb_wen, 0);
        @(negedge clk);
        #1 check("t2_busy2", busy_wait, 1);
        @(negedge clk);
        rdata_valid = 2'b01; rdata = {32'h0, 32'h0080_0000};
        #1 check("t2_busy3", busy_wait, 1);
        check("t2_ready_wait", in_ready, 0);
        @(negedge clk);
        rdata_valid = 2'b00;
        #1;
        check("t2_busy_done", busy_wait, 0);
        check("t2_wen", wb_wen, 2'b01);
        check("t2_lb", wb_wdata[31:0], 32'hFFFF_FF80);
        // LBU, zero-wait response
        set_lane(0, 5'd7, 32'h0, 3'd2, 2'd2, 32'h0, 32'h208);
        in_valid = 1'b1; rdata_valid = 2'b01;
        @(negedge clk);
        in_valid = 1'b0; rdata_valid = 2'b00;
        #1;
        check("t2_lbu_busy", busy_wait, 0);
        check("t2_lbu", wb_wdata[31:0], 32'h0000_0080);

        // 3: LWL lane 0, LWR lane 1
        @(negedge clk);
        set_lane(0, 5'd8, 32'h0, 3'd6, 2'd1, 32'hAABB_CCDD, 32'h300);
        set_lane(1, 5'd9, 32'h0, 3'd7, 2'd1, 32'hAABB_CCDD, 32'h304);
        in_valid = 1'b1; rdata_valid = 2'b11; rdata = {32'h1122_3344, 32'h1122_3344};
        @(negedge clk);
        in_valid = 1'b0; rdata_valid = 2'b00;
        #1;
        check("t3_wen", wb_wen, 2'b11);
        check("t3_lwl", wb_wdata[31:0], 32'h3344_CCDD);
        check("t3_lwr", wb_wdata[63:32], 32'hAA11_2233);
        check("t3_fwd", fwd_data, {32'hAA11_2233, 32'h3344_CCDD});

        // 4: same destination in both lanes
        @(negedge clk);
        set_lane(0, 5'd5, 32'hAA, 3'd0, 2'd0, 32'h0, 32'h400);
        set_lane(1, 5'd5, 32'hBB, 3'd0, 2'd0, 32'h0, 32'h404);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("t4_wen", wb_wen, 2'b10);
        check("t4_wdata1", wb_wdata[63:32], 32'hBB);
        @(negedge clk);
        #1 check("t4_dbg_wen", debug_wen, 8'hF0);

        // 5: flush while waiting, stale response dropped
        set_lane(0, 5'd10, 32'h0, 3'd5, 2'd0, 32'h0, 32'h500);
        set_lane(1, 5'd0, 32'h0, 3'd0, 2'd0, 32'h0, 32'h504);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b1;
        #1 check("t5_busy_pre", busy_wait, 1);
        check("t5_wen_flush", wb_wen, 0);
        @(negedge clk);
        flush = 1'b0;
        set_lane(0, 5'd11, 32'h0, 3'd5, 2'd0, 32'h0, 32'h508);
        in_valid = 1'b1;
        #1 check("t5_flushed", busy_wait, 0);
        check("t5_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0; rdata_valid = 2'b01; rdata = {32'h0, 32'h0000_DEAD};
        #1 check("t5_wait", busy_wait, 1);
        @(negedge clk);
        rdata = {32'h0, 32'h0000_BEEF};
        #1 check("t5_stale_dropped", busy_wait, 1);
        check("t5_no_wen", wb_wen, 0);
        @(negedge clk);
        rdata_valid = 2'b00;
        #1;
        check("t5_wen", wb_wen, 2'b01);
        check("t5_wdata", wb_wdata[31:0], 32'h0000_BEEF);
        check("t5_wnum", wb_wnum[4:0], 5'd11);

        // 6: commit stall then retire-and-refill
        @(negedge clk);
        set_lane(0, 5'd12, 32'h66, 3'd0, 2'd0, 32'h0, 32'h600);
        in_valid = 1'b1; commit_ok = 1'b0;
        #1 check("t6_ready_empty", in_ready, 1);
        @(negedge clk);
        set_lane(0, 5'd13, 32'h77, 3'd0, 2'd0, 32'h0, 32'h604);
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t6_stall_ready", in_ready, 0);
            check("t6_stall_wen", wb_wen, 0);
            check("t6_stall_data", fwd_data[31:0], 32'h66);
            @(negedge clk);
        end
        commit_ok = 1'b1;
        #1;
        check("t6_rel_ready", in_ready, 1);
        check("t6_rel_wen", wb_wen, 2'b01);
        check("t6_rel_wdata", wb_wdata[31:0], 32'h66);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("t6_refill_wen", wb_wen, 2'b01);
        check("t6_refill_wdata", wb_wdata[31:0], 32'h77);
        check("t6_dbg_wdata", debug_wdata[31:0], 32'h66);
        @(negedge clk);
        #1;
        check("t6_empty_ready", in_ready, 1);
        check("t6_empty_wen", wb_wen, 0);
        check("t6_empty_fwd", fwd_ready, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
